// File: rtl/melody_sequencer_pkg.sv
// Shared encodings and default widths for the melody sequencer.
// FSM state type plus BW/IDX_W/TEMPO_W defaults.
`ifndef MELODY_SEQUENCER_PKG_SV
`define MELODY_SEQUENCER_PKG_SV
package melody_sequencer_pkg;

  localparam int BW_DEF      = 16;
  localparam int IDX_W_DEF   = 7;
  localparam int TEMPO_W_DEF = 24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

endpackage
`endif

// File: rtl/melody_sequencer_note_timer.sv
// note_timer: per-note tick counter with terminal compares.
// Ports: clk_i, rst_i, clr_i, en_i, len_i, gap_i -> play_end_o, note_end_o.
module note_timer #(
  parameter int TEMPO_W = 24
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [TEMPO_W-1:0] len_i,
  input  logic [TEMPO_W-1:0] gap_i,
  output logic               play_end_o,
  output logic               note_end_o
);

  logic [TEMPO_W-1:0] tick_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      tick_cnt <= '0;
    end else if (en_i) begin
      tick_cnt <= tick_cnt + TEMPO_W'(1);
    end
  end

  // gap_i < len_i and len_i >= 1 are guaranteed by the latch logic
  assign play_end_o =
    (tick_cnt == len_i - gap_i - TEMPO_W'(1));
  assign note_end_o =
    (tick_cnt == len_i - TEMPO_W'(1));

endmodule

// File: rtl/melody_sequencer.sv
// Steps NotesRom at a programmable tempo, with articulation gaps.
// Ports: start/stop/loop control, tempo, ROM addr/data, divider, status.
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int BW        = BW_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int NUM_NOTES = 64,
  parameter int TEMPO_W   = TEMPO_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               loop_en_i,
  input  logic [TEMPO_W-1:0] note_len_i,
  input  logic [TEMPO_W-1:0] gap_len_i,
  output logic [IDX_W-1:0]   note_index_o,
  input  logic [BW-1:0]      divider_value_i,
  output logic [BW-1:0]      divider_value_o,
  output logic               note_strobe_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_NOTES - 1);

  state_t             state;
  logic [TEMPO_W-1:0] len_q;
  logic [TEMPO_W-1:0] gap_q;
  logic [TEMPO_W-1:0] len_n;
  logic [TEMPO_W-1:0] gap_n;
  logic               play_end;
  logic               note_end;
  logic               tick_en;
  logic               note_done;

  assign len_n = (note_len_i == '0) ?
                 TEMPO_W'(1) : note_len_i;
  assign gap_n = (gap_len_i >= len_n) ?
                 '0 : gap_len_i;

  assign tick_en = (state == S_PLAY) ||
                   (state == S_GAP);

  assign note_done =
    ((state == S_PLAY) && play_end &&
     (gap_q == '0)) ||
    ((state == S_GAP) && note_end);

  assign busy_o = (state != S_IDLE);

  note_timer #(
    .TEMPO_W (TEMPO_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (!tick_en),
    .en_i       (tick_en),
    .len_i      (len_q),
    .gap_i      (gap_q),
    .play_end_o (play_end),
    .note_end_o (note_end)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      len_q           <= '0;
      gap_q           <= '0;
      note_index_o    <= '0;
      divider_value_o <= '0;
      note_strobe_o   <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      note_strobe_o <= 1'b0;
      done_o        <= 1'b0;
      if (stop_i && (state != S_IDLE)) begin
        state           <= S_IDLE;
        divider_value_o <= '0;
        note_index_o    <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            note_index_o <= '0;
            if (start_i && !stop_i) begin
              len_q <= len_n;
              gap_q <= gap_n;
              state <= S_LOAD;
            end
          end
          S_LOAD: begin
            divider_value_o <= divider_value_i;
            note_strobe_o   <= 1'b1;
            state           <= S_PLAY;
          end
          S_PLAY: begin
            if (play_end && (gap_q != '0)) begin
              divider_value_o <= '0;
              state           <= S_GAP;
            end
          end
          S_GAP: begin
          end
        endcase
        // LOAD cycles are silent so back-to-back notes stay articulated
        if (note_done) begin
          divider_value_o <= '0;
          if (note_index_o < LAST_IDX) begin
            note_index_o <= note_index_o + IDX_W'(1);
            state        <= S_LOAD;
          end else if (loop_en_i) begin
            note_index_o <= '0;
            state        <= S_LOAD;
          end else begin
            note_index_o <= '0;
            done_o       <= 1'b1;
            state        <= S_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized self-checking bench for melody_sequencer.
// Reference model tracks playback by elapsed-clock arithmetic.
module tb_melody_sequencer;

  localparam int BW  = 16;
  localparam int IW  = 7;
  localparam int NN  = 4;
  localparam int TW  = 24;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [TW-1:0] note_len;
  logic [TW-1:0] gap_len;
  logic [IW-1:0] idx;
  logic [BW-1:0] rom_data;
  logic [BW-1:0] div;
  logic          strobe;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_busy = 0;
  bit m_done = 0;
  int m_pos  = 0;
  int m_len  = 1;
  int m_gap  = 0;

  function automatic logic [BW-1:0] rom_val(int i);
    case (i)
      0: return 16'd100;
      1: return 16'd0;
      2: return 16'd300;
      3: return 16'd400;
      default: return 16'hdead;
    endcase
  endfunction

  assign rom_data = rom_val(int'(idx));

  melody_sequencer #(
    .BW        (BW),
    .IDX_W     (IW),
    .NUM_NOTES (NN),
    .TEMPO_W   (TW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stop_i          (stop),
    .loop_en_i       (loop_en),
    .note_len_i      (note_len),
    .gap_len_i       (gap_len),
    .note_index_o    (idx),
    .divider_value_i (rom_data),
    .divider_value_o (div),
    .note_strobe_o   (strobe),
    .busy_o          (busy),
    .done_o          (done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int ph;
    int note;
    int l;
    m_done = 0;
    if (rst) begin
      m_busy = 0;
    end else if (m_busy && stop) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        l = (note_len == 0) ? 1 : int'(note_len);
        m_len  = l;
        m_gap  = (int'(gap_len) >= l) ? 0 : int'(gap_len);
        m_pos  = 0;
        m_busy = 1;
      end
    end else begin
      ph   = m_pos % (m_len + 1);
      note = m_pos / (m_len + 1);
      if (ph == m_len && note == NN - 1) begin
        if (loop_en) begin
          m_pos = 0;
        end else begin
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic check_outputs();
    int ph;
    int note;
    logic [31:0] e_idx;
    logic [31:0] e_div;
    logic [31:0] e_str;
    e_idx = 0;
    e_div = 0;
    e_str = 0;
    if (m_busy) begin
      ph    = m_pos % (m_len + 1);
      note  = m_pos / (m_len + 1);
      e_idx = note;
      if (ph >= 1 && ph <= m_len - m_gap)
        e_div = {16'd0, rom_val(note)};
      e_str = (ph == 1) ? 1 : 0;
    end
    check("index",  {25'd0, idx}, e_idx);
    check("divider", {16'd0, div}, e_div);
    check("strobe", {31'd0, strobe}, e_str);
    check("busy",   {31'd0, busy}, {31'd0, m_busy});
    check("done",   {31'd0, done}, {31'd0, m_done});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic wait_idle(int bound);
    int k = 0;
    while (busy && k < bound) begin
      cycle();
      k++;
    end
    check("idle_timeout", {31'd0, busy}, 0);
  endtask

  task automatic go(int l, int g, bit lp);
    note_len = TW'(l);
    gap_len  = TW'(g);
    loop_en  = lp;
    start    = 1;
    cycle();
    start    = 0;
  endtask

  initial begin
    int dcount;
    rst      = 1;
    start    = 0;
    stop     = 0;
    loop_en  = 0;
    note_len = 0;
    gap_len  = 0;
    @(negedge clk);
    run(2);
    rst = 0;
    run(2);

    // nominal pass: 20 clocks, done then idle
    go(4, 1, 0);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (done) dcount++;
    end
    check("t1_done_at_20", {31'd0, done}, 1);
    check("t1_done_once", dcount, 1);
    cycle();
    check("t1_busy_after", {31'd0, busy}, 0);

    // no gap, then clamped gap
    go(3, 0, 0);
    wait_idle(100);
    go(4, 5, 0);
    wait_idle(100);

    // looping: two full passes, then release loop
    go(2, 0, 1);
    dcount = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (done) dcount++;
    end
    check("t3_no_done_loop", dcount, 0);
    loop_en = 0;
    wait_idle(100);

    // stop during note 2, then stop+start from idle
    go(4, 1, 0);
    run(12);
    check("t4_pre_stop_div", {16'd0, div}, 300);
    stop = 1;
    cycle();
    stop = 0;
    check("t4_stop_busy", {31'd0, busy}, 0);
    stop  = 1;
    start = 1;
    cycle();
    stop  = 0;
    start = 0;
    run(3);

    // start while busy is ignored; zero length acts as 1
    go(4, 1, 0);
    run(3);
    note_len = 9;
    start    = 1;
    cycle();
    start    = 0;
    wait_idle(100);
    go(0, 0, 0);
    wait_idle(100);

    // reset in the gap of note 1, then a fresh pass
    go(4, 1, 0);
    run(9);
    rst = 1;
    cycle();
    rst = 0;
    check("t6_rst_div", {16'd0, div}, 0);
    go(4, 1, 0);
    wait_idle(100);

    // randomized sessions
    for (int it = 0; it < 30; it++) begin
      go($urandom_range(0, 8), $urandom_range(0, 9),
         1'($urandom_range(0, 1)));
      for (int c = 0; c < 150 && busy; c++) begin
        stop  = ($urandom_range(0, 99) < 2);
        rst   = ($urandom_range(0, 199) < 1);
        start = ($urandom_range(0, 99) < 10);
        if (start) note_len = TW'($urandom_range(0, 9));
        if ($urandom_range(0, 99) < 5)
          loop_en = ~loop_en;
        if (c > 100) loop_en = 0;
        cycle();
      end
      stop    = 0;
      rst     = 0;
      start   = 0;
      loop_en = 0;
      wait_idle(200);
      run(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
